// File: rtl/gray_decoder_if.sv
// Bus between a Gray-code producer and the gray_decoder: sampled code,
// qualifier and soft clear inbound, reconstructed counter status outbound.
interface gray_decoder_if #(
   parameter int WIDTH  = 3,
   parameter int WRAP_W = 8
);
   logic              Clear;
   logic              Valid;
   logic [WIDTH-1:0]  Gray;
   logic [WIDTH-1:0]  Binary;
   logic              Locked;
   logic              Overflow;
   logic [WRAP_W-1:0] Wraps;
   logic              Error;

   modport master (
      output Clear,
      output Valid,
      output Gray,
      input  Binary,
      input  Locked,
      input  Overflow,
      input  Wraps,
      input  Error
   );

   modport slave (
      input  Clear,
      input  Valid,
      input  Gray,
      output Binary,
      output Locked,
      output Overflow,
      output Wraps,
      output Error
   );
endinterface

// File: rtl/gray_decoder.sv
// Gray-code stream decoder: converts each accepted sample to binary and checks
// that the stream only holds or advances by one, tracking wraps and faults.
module gray_decoder #(
   parameter int WIDTH  = 3,
   parameter int WRAP_W = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   gray_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'b00,
      ST_LOCKED   = 2'b01,
      ST_FAULT    = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0]  BIN_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]  BIN_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]  BIN_MAX   = {WIDTH{1'b1}};
   localparam logic [WRAP_W-1:0] WRAP_ZERO = {WRAP_W{1'b0}};
   localparam logic [WRAP_W-1:0] WRAP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};
   localparam logic [WRAP_W-1:0] WRAP_MAX  = {WRAP_W{1'b1}};

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   state_t            state_r;
   state_t            state_s;
   logic [WIDTH-1:0]  binary_r;
   logic [WIDTH-1:0]  binary_s;
   logic              locked_r;
   logic              locked_s;
   logic              overflow_r;
   logic              overflow_s;
   logic [WRAP_W-1:0] wraps_r;
   logic [WRAP_W-1:0] wraps_s;
   logic              error_r;
   logic              error_s;
   logic [WIDTH-1:0]  nb_s;
   logic [WIDTH-1:0]  step_s;

   // Next-state and next-output decode for the lock/step checker.
   always_comb begin
      nb_s       = gray2bin(bus.Gray);
      step_s     = nb_s - binary_r;
      state_s    = state_r;
      binary_s   = binary_r;
      locked_s   = locked_r;
      overflow_s = overflow_r;
      wraps_s    = wraps_r;
      error_s    = error_r;
      case (state_r)
         ST_UNLOCKED: begin
            if (bus.Valid) begin
               binary_s = nb_s;
               locked_s = 1'b1;
               state_s  = ST_LOCKED;
            end else begin
               state_s = ST_UNLOCKED;
            end
         end
         ST_LOCKED: begin
            if (!bus.Valid || (step_s == BIN_ZERO)) begin
               state_s = ST_LOCKED;
            end else if (step_s == BIN_ONE) begin
               binary_s = nb_s;
               // A legal +1 step out of all-ones can only land on zero.
               if (binary_r == BIN_MAX) begin
                  overflow_s = 1'b1;
                  if (wraps_r != WRAP_MAX) begin
                     wraps_s = wraps_r + WRAP_ONE;
                  end else begin
                     wraps_s = wraps_r;
                  end
               end else begin
                  overflow_s = overflow_r;
               end
            end else begin
               error_s  = 1'b1;
               locked_s = 1'b0;
               state_s  = ST_FAULT;
            end
         end
         ST_FAULT: begin
            state_s = ST_FAULT;
         end
         default: begin
            state_s  = ST_UNLOCKED;
            locked_s = 1'b0;
         end
      endcase
   end

   // State and output registers with async reset and synchronous clear.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r    <= ST_UNLOCKED;
         binary_r   <= BIN_ZERO;
         locked_r   <= 1'b0;
         overflow_r <= 1'b0;
         wraps_r    <= WRAP_ZERO;
         error_r    <= 1'b0;
      end else if (bus.Clear) begin
         state_r    <= ST_UNLOCKED;
         binary_r   <= BIN_ZERO;
         locked_r   <= 1'b0;
         overflow_r <= 1'b0;
         wraps_r    <= WRAP_ZERO;
         error_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         binary_r   <= binary_s;
         locked_r   <= locked_s;
         overflow_r <= overflow_s;
         wraps_r    <= wraps_s;
         error_r    <= error_s;
      end
   end

   assign bus.Binary   = binary_r;
   assign bus.Locked   = locked_r;
   assign bus.Overflow = overflow_r;
   assign bus.Wraps    = wraps_r;
   assign bus.Error    = error_r;

endmodule

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
- Receiving end of the Gray-code counter interface: samples a WIDTH-bit Gray code stream, converts each sample to binary, and checks that the stream advances in legal single steps.
- Reconstructs the counter value, wrap count and overflow flag on the consumer side of the counter.
- Flags any illegal jump as a sticky error.
- Sits directly downstream of the Gray counter, or after a CDC synchroniser on its output bus.

Parameters:
- WIDTH, 3, Gray/binary code width (>=2)
- WRAP_W, 8, width of wrap counter

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Clear  in  1  synchronous clear: returns block to reset state; lower priority than Reset
- Valid  in  1  Gray is sampled on rising Clk when high
- Gray  in  WIDTH  incoming Gray code
- Binary  out  WIDTH  registered binary value of last accepted code
- Locked  out  1  high once a first code has been accepted and no fault has occurred
- Overflow  out  1  sticky; set on first wrap from max to 0
- Wraps  out  WRAP_W  saturating count of wraps
- Error  out  1  sticky; illegal step detected

Behaviour:
- Reset (async) or Clear (sync): Binary=0, Locked=0, Overflow=0, Wraps=0, Error=0, state=UNLOCKED.
- Conversion, combinational on input: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Call the result nb. All outputs are registered, so results appear the cycle after the Valid edge.
- Step: d = (nb - Binary) mod 2^WIDTH, WIDTH-bit unsigned.
- UNLOCKED state:
  - Valid=1: Binary<=nb, Locked<=1, go to LOCKED.
  - Any start value is accepted; no wrap counted.
- LOCKED state, Valid=1:
  - d==0 (hold, i.e. counter not enabled): no change.
  - d==1: Binary<=nb.
  - d==1 with Binary==all-ones and nb==0 (wrap): additionally Overflow<=1; Wraps<=Wraps+1, saturating at all-ones.
  - Any other d (skip, backward step): Error<=1, Locked<=0, go to FAULT. Binary keeps its last good value.
- FAULT state: Valid and Gray ignored; stays in FAULT until Reset or Clear.
- Valid=0 in any state: all state and outputs hold.
- Clear and Valid in the same cycle: Clear wins; the sample is discarded.
- Reset asserted mid-stream: outputs go to reset values immediately, without waiting for Clk. After release, the next Valid relocks at whatever code is present.
- No illegal-state recovery is needed beyond encoding FAULT; an unused state encoding returns to UNLOCKED.

Test Plan:
- WIDTH=3, reset then Valid each cycle with 000,001,011,010,110,111,101,100,000 -> Binary 0,1,2,3,4,5,6,7,0; Locked=1 from first sample; Overflow=1 and Wraps=1 only after the final sample; Error=0.
- Locked at 011, then Valid with 011 three times, then Valid=0 with Gray=110 -> Binary stays 2; no error.
- Locked at 001, then 010 (skip 1->3) -> Error=1, Locked=0, Binary=1; further legal codes are ignored. Clear then 010 -> Locked=1, Binary=3, Error=0.
- Locked at 110 (4), then 010 (3, backward) -> Error=1, Binary=4.
- WRAP_W=2: run 5 full cycles of the sequence -> Wraps reads 1,2,3,3,3; Overflow=1 throughout after the first wrap.
- Reset pulsed between clock edges while Binary=5, Wraps=1 -> all outputs 0 before the next edge. Next Valid with 101 -> Locked=1, Binary=6, no wrap counted.
